decode_issue_queue: RTL
=======================

# decode_issue_queue

Instruction buffer and issue controller between fetch and decode in the mycpu pipeline. Accepts fetched instruction words with their PCs, buffers them in a small FIFO, and presents the oldest entry to the instruction field decoder and the decode stage under a valid/allowin handshake. Handles exception flush and taken-branch redirect, preserving the MIPS branch delay slot and tagging it with a delay-slot flag.

## Interface

- DEPTH, 4, number of entries; power of two, 2 to 16
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden

- clk  input  1  pipeline clock, rising edge
- resetn  input  1  synchronous active-low reset
- fs_valid  input  1  fetch presents a word this cycle
- fs_inst  input  32  fetched instruction word
- fs_pc  input  32  PC of fs_inst
- fs_target  input  1  qualifies fs_valid: word is first instruction at redirect target
- fs_ready  output  1  queue accepts a word this cycle
- ds_valid  output  1  head entry valid, drives decoder inst input
- ds_inst  output  32  head instruction word
- ds_pc  output  32  head PC
- ds_bd  output  1  head entry is a branch delay slot
- ds_allowin  input  1  decode stage consumes head this cycle
- br_redirect  input  1  branch issued this cycle (pop handshake) resolved taken
- flush  input  1  exception/ERET flush, highest priority

## Operation

- Push: fs_valid & fs_ready & !drop_mode. Pop: ds_valid & ds_allowin.
- Storage: DEPTH entries of {inst[31:0], pc[31:0], bd}; rptr, wptr (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits, 0..DEPTH).
- fs_ready = (count != DEPTH) — from registered count only, no dependency on ds_allowin.
- ds_valid = (count != 0); ds_inst/ds_pc/ds_bd read combinationally from entry[rptr].
- Simultaneous push and pop: count unchanged, both pointers advance.
- Control states: RUN, WAIT_SLOT, DROP.
  - RUN: normal push/pop; pushed bd = 0.
  - br_redirect in RUN (only valid together with a pop): if count−1 ≥ 1, keep exactly the entry after the popped branch, mark its bd = 1, discard all younger entries and any same-cycle push, go to DROP. If count−1 = 0 and a same-cycle push occurs, keep that word with bd = 1, go to DROP. Otherwise go to WAIT_SLOT.
  - WAIT_SLOT: next push stored with bd = 1, then go to DROP; fs_target is ignored in this state (delay slot is never a target word).
  - DROP: fs_ready follows the normal rule, but pushes with fs_target = 0 are accepted and discarded. A push with fs_target = 1 is stored (bd = 0) and returns to RUN in the same cycle.
- flush: count ← 0, rptr ← wptr ← 0, state ← DROP; same-cycle push and pop discarded. Fetch signals resumption with fs_target.
- Priority: !resetn > flush > br_redirect > push/pop.
- br_redirect without a pop handshake is ignored.

## Timing

- Reset (resetn low at rising edge): count 0, pointers 0, state RUN, all entries' inst/pc/bd cleared to 0. After reset: fs_ready 1, ds_valid 0, ds_inst 0 (NOP), ds_pc 0, ds_bd 0.
- Push-to-issue latency: word pushed at edge N visible on ds_valid/ds_inst after edge N; no bypass when empty.
- Full: fs_ready low; a pop at the same edge does not enable a push.
- Empty: ds_valid low; ds_allowin ignored.
- Flush or redirect effects visible one cycle after the asserting edge.
- Throughput: one push and one pop per cycle sustained.

## Test plan

- Reset then stream PCs 0xBFC00000, +4, +8 with ds_allowin = 1 -> each appears on ds_pc exactly 1 cycle after its push; ds_bd 0; count never exceeds 1.
- DEPTH = 4, ds_allowin = 0, push 5 words -> fs_ready low after the 4th push; 5th word held by fetch; release ds_allowin -> words issue in order with no loss or duplication.
- Queue holds branch at 0x100 plus 0x104, 0x108, 0x10C; pop the branch with br_redirect -> ds_pc 0x104 with ds_bd 1; 0x108/0x10C never issue; pushes of 0x110 are dropped; push 0x200 with fs_target -> issues after 0x104 with ds_bd 0.
- Branch pops with br_redirect while the queue is otherwise empty -> WAIT_SLOT; next push 0x104 issues with ds_bd 1; following push 0x108 (fs_target 0) is dropped.
- flush with 3 entries, simultaneous push and pop -> next cycle ds_valid 0, fs_ready 1; non-target pushes dropped until fs_target word (PC 0xBFC00380) is accepted.
- resetn low mid-stream with queue full and in DROP -> next cycle all outputs at reset values and state RUN; next push accepted normally.

Source files
------------

// File: rtl/decode_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : decode_issue_queue
//  Purpose  : Instruction buffer between fetch and decode. Buffers fetched
//             {inst, pc} words in a small FIFO and presents the oldest entry
//             to decode under a valid/allowin handshake. It handles two kinds
//             of control transfer:
//             - Exception/ERET flush: the queue is emptied and fetched words
//               are discarded until fetch marks the first target word.
//             - Taken-branch redirect: exactly one branch delay slot is kept
//               and tagged with ds_bd, and younger wrong-path words are
//               discarded.
//  Ports    : clk, resetn            - clock, synchronous active-low reset
//             fs_valid/fs_inst/fs_pc - fetched word and its PC
//             fs_target              - word is the first one at a redirect
//                                      target
//             fs_ready               - queue can take a word this cycle
//             ds_valid/ds_inst/ds_pc/ds_bd - head entry presented to decode
//             ds_allowin             - decode consumes the head entry
//             br_redirect            - the branch being popped resolved taken
//             flush                  - exception/ERET flush
//  Revision : 1.0 - initial release
// ============================================================================
module decode_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fs_valid,
  input  logic [31:0] fs_inst,
  input  logic [31:0] fs_pc,
  input  logic        fs_target,
  output logic        fs_ready,
  output logic        ds_valid,
  output logic [31:0] ds_inst,
  output logic [31:0] ds_pc,
  output logic        ds_bd,
  input  logic        ds_allowin,
  input  logic        br_redirect,
  input  logic        flush
);

  // Control states
  localparam logic [1:0] c_run       = 2'd0;
  localparam logic [1:0] c_wait_slot = 2'd1;
  localparam logic [1:0] c_drop      = 2'd2;

  localparam logic [PTR_W:0]   c_cnt_full = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   c_cnt_one  = (PTR_W + 1)'(1);
  // Wraps modulo DEPTH; for DEPTH = 2 this truncates to 0, which is correct.
  localparam logic [PTR_W-1:0] c_ptr_two  = PTR_W'(2);

  // Entry storage
  logic [31:0] r_inst [DEPTH];
  logic [31:0] r_pc   [DEPTH];
  logic        r_bd   [DEPTH];

  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W:0]   r_count;
  logic [1:0]       r_state;

  logic [PTR_W-1:0] w_rptr_nxt;
  logic [PTR_W-1:0] w_wptr_nxt;
  logic [PTR_W:0]   w_count_nxt;
  logic [1:0]       w_state_nxt;

  logic             w_push_req;
  logic             w_pop;
  logic             w_redirect;
  logic             w_wr_en;
  logic             w_wr_bd;
  logic             w_slot_mark;
  logic [PTR_W-1:0] w_slot_idx;

  // fs_ready is derived from the registered count only. A pop in the same
  // cycle therefore never opens a slot for a push.
  assign fs_ready = (r_count != c_cnt_full);
  assign ds_valid = (r_count != '0);
  assign ds_inst  = r_inst[r_rptr];
  assign ds_pc    = r_pc[r_rptr];
  assign ds_bd    = r_bd[r_rptr];

  assign w_push_req = fs_valid & fs_ready;
  assign w_pop      = ds_valid & ds_allowin;
  // A redirect only has meaning together with the pop of the branch itself.
  // It is acted on only in RUN.
  assign w_redirect = br_redirect & w_pop & (r_state == c_run);
  // The entry directly behind the popped branch is its delay slot.
  assign w_slot_idx = r_rptr + 1'b1;

  always_comb begin
    w_rptr_nxt  = r_rptr;
    w_wptr_nxt  = r_wptr;
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_bd     = 1'b0;
    w_slot_mark = 1'b0;

    if (flush) begin
      w_rptr_nxt  = '0;
      w_wptr_nxt  = '0;
      w_count_nxt = '0;
      w_state_nxt = c_drop;
    end else if (w_redirect) begin
      w_rptr_nxt  = r_rptr + 1'b1;
      w_state_nxt = c_drop;
      if (r_count > c_cnt_one) begin
        // The delay slot is already buffered. Keep only that entry, and
        // truncate the queue just behind it.
        w_wptr_nxt  = r_rptr + c_ptr_two;
        w_count_nxt = c_cnt_one;
        w_slot_mark = 1'b1;
      end else if (w_push_req) begin
        // The delay slot arrives in this same cycle. Take it directly.
        w_wr_en     = 1'b1;
        w_wr_bd     = 1'b1;
        w_wptr_nxt  = r_wptr + 1'b1;
        w_count_nxt = c_cnt_one;
      end else begin
        w_count_nxt = '0;
        w_state_nxt = c_wait_slot;
      end
    end else begin
      case (r_state)
        c_run: begin
          w_wr_en = w_push_req;
        end
        c_wait_slot: begin
          // The delay slot is never a target word, so fs_target is ignored.
          if (w_push_req) begin
            w_wr_en     = 1'b1;
            w_wr_bd     = 1'b1;
            w_state_nxt = c_drop;
          end
        end
        c_drop: begin
          // Wrong-path words are accepted from fetch and then discarded.
          if (w_push_req && fs_target) begin
            w_wr_en     = 1'b1;
            w_state_nxt = c_run;
          end
        end
        default: begin
          w_state_nxt = c_run;
        end
      endcase

      if (w_wr_en) begin
        w_wptr_nxt = r_wptr + 1'b1;
      end
      if (w_pop) begin
        w_rptr_nxt = r_rptr + 1'b1;
      end
      if (w_wr_en && !w_pop) begin
        w_count_nxt = r_count + 1'b1;
      end else if (!w_wr_en && w_pop) begin
        w_count_nxt = r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_state <= c_run;
    end else begin
      r_rptr  <= w_rptr_nxt;
      r_wptr  <= w_wptr_nxt;
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Entries are cleared on reset so that the empty head reads as a NOP at
  // PC 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_inst[i] <= '0;
        r_pc[i]   <= '0;
        r_bd[i]   <= 1'b0;
      end
    end else begin
      if (w_wr_en) begin
        r_inst[r_wptr] <= fs_inst;
        r_pc[r_wptr]   <= fs_pc;
        r_bd[r_wptr]   <= w_wr_bd;
      end
      if (w_slot_mark) begin
        r_bd[w_slot_idx] <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
